// File: rtl/riscv_dmem_arbiter.sv
// riscv_dmem_arbiter: shares the single-port data RAM between the core
// load/store unit (port 0) and the accelerator / sensor DMA (port 1).
// The core has fixed priority. A starvation guard force-grants port 1 after
// STARVE_LIMIT consecutive denied cycles. Port 1 may hold ownership for a
// locked burst of up to BURST_MAX beats.
// Grants are combinational. Read data is registered, with one cycle of latency.
// Optional: define RISCV_DMEM_ARB_STATS_EN to add the conflict_cnt output.
module riscv_dmem_arbiter #(
  parameter int unsigned AW           = 7,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned BURST_MAX    = 16,
  parameter int unsigned CW           = 5
) (
  input  logic          clk,
  input  logic          rst,
  // port 0: core load/store unit
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [31:0]   p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [31:0]   p0_rdata,
  // port 1: accelerator / sensor DMA
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wdata,
  input  logic          p1_lock,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [31:0]   p1_rdata,
  // data RAM side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
`ifdef RISCV_DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   conflict_cnt
`endif
);

  typedef enum logic {
    S_CPU = 1'b0,
    S_ACC = 1'b1
  } state_t;

  localparam logic [CW-1:0] STARVE_LIM_C = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] BURST_MAX_C  = CW'(BURST_MAX);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  // A one-beat burst limit makes the lock meaningless, so S_ACC is never entered.
  localparam logic          LOCK_EN      = (BURST_MAX > 1);

  state_t        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [CW-1:0] burst_q, burst_d;
  logic          gnt0, gnt1;
  logic          force_p1;

  logic          p0_rvalid_q, p1_rvalid_q;
  logic [31:0]   p0_rdata_q, p1_rdata_q;

  // Arbitration: grant decision, starvation counter and burst tracking.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    burst_d  = burst_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    force_p1 = 1'b0;
    if (!rst) begin
      case (state_q)
        S_CPU: begin
          force_p1 = p1_req && (starve_q >= STARVE_LIM_C);
          if (force_p1) begin
            gnt1 = 1'b1;
          end else if (p0_req) begin
            gnt0 = 1'b1;
          end else if (p1_req) begin
            gnt1 = 1'b1;
          end
          if (p1_req && !gnt1) begin
            starve_d = (starve_q == '1) ? starve_q : starve_q + CNT_ONE;
          end else begin
            starve_d = '0;
          end
          if (gnt1 && p1_lock && LOCK_EN) begin
            state_d = S_ACC;
            burst_d = CNT_ONE;
          end
        end
        S_ACC: begin
          starve_d = '0;
          if (p1_req) begin
            gnt1 = 1'b1;
            // The beat that ends the burst is still granted.
            if (!p1_lock || ((burst_q + CNT_ONE) == BURST_MAX_C)) begin
              state_d = S_CPU;
              burst_d = '0;
            end else begin
              burst_d = burst_q + CNT_ONE;
            end
          end else begin
            // Port 1 went idle: hand the RAM back to the core in this same cycle.
            gnt0    = p0_req;
            state_d = S_CPU;
            burst_d = '0;
          end
        end
        default: begin
          state_d  = S_CPU;
          starve_d = '0;
          burst_d  = '0;
        end
      endcase
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_CPU;
      starve_q <= '0;
      burst_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      burst_q  <= burst_d;
    end
  end

  // RAM-side mux: signals come from the granted port and are zero when idle.
  always_comb begin
    mem_en    = gnt0 | gnt1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = p0_we;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (gnt1) begin
      mem_we    = p1_we;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  // Read return path: capture RAM data on a read grant and pulse rvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      p0_rvalid_q <= gnt0 && !p0_we;
      p1_rvalid_q <= gnt1 && !p1_we;
      if (gnt0 && !p0_we) begin
        p0_rdata_q <= mem_rdata;
      end
      if (gnt1 && !p1_we) begin
        p1_rdata_q <= mem_rdata;
      end
    end
  end

  assign p0_gnt    = gnt0;
  assign p1_gnt    = gnt1;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

`ifdef RISCV_DMEM_ARB_STATS_EN
  logic [15:0] conflict_q;

  // Count cycles in which both ports request, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= '0;
    end else if (p0_req && p1_req && (conflict_q != '1)) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Self-checking bench for riscv_dmem_arbiter. It uses directed scenarios
// followed by random traffic, and checks against a behavioural reference model.
module tb_riscv_dmem_arbiter;

  localparam int AW           = 7;
  localparam int STARVE_LIMIT = 8;
  localparam int BURST_MAX    = 16;
  localparam int CW           = 5;
  localparam int SAT          = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req, p0_we, p0_gnt, p0_rvalid;
  logic [AW-1:0] p0_addr;
  logic [31:0]   p0_wdata, p0_rdata;
  logic          p1_req, p1_we, p1_gnt, p1_rvalid, p1_lock;
  logic [AW-1:0] p1_addr;
  logic [31:0]   p1_wdata, p1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
`ifdef RISCV_DMEM_ARB_STATS_EN
  logic [15:0]   conflict_cnt;
`endif

  riscv_dmem_arbiter #(
    .AW(AW), .STARVE_LIMIT(STARVE_LIMIT), .BURST_MAX(BURST_MAX), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_lock(p1_lock),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef RISCV_DMEM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Data RAM: synchronous write, combinational read, plus a backdoor for preload.
  logic [31:0]   ram [0:(1<<AW)-1];
  logic          bd_fill, bd_we;
  logic [AW-1:0] bd_addr;
  logic [31:0]   bd_data;

  function automatic logic [31:0] fill_word(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk) begin
    if (bd_fill) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= fill_word(i);
    end else if (bd_we) begin
      ram[bd_addr] <= bd_data;
    end else if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = ram[mem_addr];

  // Reference model state
  int          errors = 0;
  int          checks = 0;
  int          m_denied = 0;   // consecutive cycles port 1 asked and lost
  bit          m_inburst = 0;  // port 1 owns the RAM for a locked burst
  int          m_beats = 0;    // beats already taken in the current burst
  int          m_conf = 0;
  logic [31:0] ref_mem [0:(1<<AW)-1];
  logic        exp_rv0 = 0, exp_rv1 = 0;
  logic [31:0] exp_rd0 = '0, exp_rd1 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle. Called at posedge+1 with inputs already driven.
  // Checks grants and the RAM mux at the negedge, and read returns after the edge.
  task automatic step(output bit o0, output bit o1);
    bit          e0, e1;
    logic        e_we;
    logic [AW-1:0] e_a;
    logic [31:0] e_d;
    #4;
    e0 = 0; e1 = 0;
    if (rst) begin
      m_denied = 0; m_inburst = 0; m_beats = 0;
    end else if (m_inburst) begin
      m_denied = 0;
      if (p1_req) begin
        e1 = 1;
        m_beats++;
        if (!p1_lock || m_beats == BURST_MAX) m_inburst = 0;
      end else begin
        e0 = p0_req;
        m_inburst = 0;
      end
    end else begin
      if (p1_req && m_denied >= STARVE_LIMIT) e1 = 1;
      else if (p0_req) e0 = 1;
      else if (p1_req) e1 = 1;
      if (p1_req && !e1) m_denied = (m_denied < SAT) ? m_denied + 1 : SAT;
      else m_denied = 0;
      if (e1 && p1_lock && BURST_MAX > 1) begin
        m_inburst = 1;
        m_beats = 1;
      end
    end
    e_we = e0 ? p0_we : (e1 ? p1_we : 1'b0);
    e_a  = e0 ? p0_addr : (e1 ? p1_addr : '0);
    e_d  = e0 ? p0_wdata : (e1 ? p1_wdata : '0);
    chk("p0_gnt", 32'(p0_gnt), 32'(e0));
    chk("p1_gnt", 32'(p1_gnt), 32'(e1));
    chk("mem_en", 32'(mem_en), 32'(e0 | e1));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", 32'(mem_addr), 32'(e_a));
    chk("mem_wdata", mem_wdata, e_d);
    o0 = p0_gnt;
    o1 = p1_gnt;
    if (rst) begin
      exp_rv0 = 0; exp_rv1 = 0; exp_rd0 = '0; exp_rd1 = '0;
      m_conf = 0;
    end else begin
      exp_rv0 = e0 && !p0_we;
      exp_rv1 = e1 && !p1_we;
      if (exp_rv0) exp_rd0 = ref_mem[p0_addr];
      if (exp_rv1) exp_rd1 = ref_mem[p1_addr];
      if (e0 && p0_we) ref_mem[p0_addr] = p0_wdata;
      if (e1 && p1_we) ref_mem[p1_addr] = p1_wdata;
      if (p0_req && p1_req && m_conf < 65535) m_conf++;
    end
    @(posedge clk);
    #1;
    chk("p0_rvalid", 32'(p0_rvalid), 32'(exp_rv0));
    chk("p1_rvalid", 32'(p1_rvalid), 32'(exp_rv1));
    chk("p0_rdata", p0_rdata, exp_rd0);
    chk("p1_rdata", p1_rdata, exp_rd1);
`ifdef RISCV_DMEM_ARB_STATS_EN
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
`endif
  endtask

  task automatic idle_inputs();
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_lock = 0;
  endtask

  initial begin
    bit o0, o1;
    bit pend0, pend1;
    pend0 = 0; pend1 = 0;
    rst = 1; idle_inputs();
    bd_fill = 1; bd_we = 0; bd_addr = '0; bd_data = '0;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = fill_word(i);
    @(posedge clk); #1;

    // Reset with RAM preload; RAM[5] = DEADBEEF
    step(o0, o1);
    bd_fill = 0; bd_we = 1; bd_addr = AW'(5); bd_data = 32'hDEAD_BEEF;
    ref_mem[5] = 32'hDEAD_BEEF;
    step(o0, o1);
    bd_we = 0;
    step(o0, o1);
    chk("reset_p0_rvalid", 32'(p0_rvalid), 32'd0);
    chk("reset_p0_rdata", p0_rdata, 32'd0);

    // p0 read of addr 5
    rst = 0;
    p0_req = 1; p0_we = 0; p0_addr = AW'(5);
    step(o0, o1);
    chk("t1_gnt", 32'(o0), 32'd1);
    chk("t1_rvalid", 32'(p0_rvalid), 32'd1);
    chk("t1_rdata", p0_rdata, 32'hDEAD_BEEF);
    chk("t1_p1_rvalid", 32'(p1_rvalid), 32'd0);
    idle_inputs();
    step(o0, o1);
    chk("t1_rvalid_pulse", 32'(p0_rvalid), 32'd0);
    chk("t1_rdata_hold", p0_rdata, 32'hDEAD_BEEF);

    // p0 write addr 3, then p1 read addr 3
    p0_req = 1; p0_we = 1; p0_addr = AW'(3); p0_wdata = 32'h1234_5678;
    step(o0, o1);
    chk("t2_wr_gnt", 32'(o0), 32'd1);
    chk("t2_wr_no_rvalid", 32'(p0_rvalid), 32'd0);
    idle_inputs();
    p1_req = 1; p1_we = 0; p1_addr = AW'(3);
    step(o0, o1);
    chk("t2_rd_gnt", 32'(o1), 32'd1);
    chk("t2_p1_rdata", p1_rdata, 32'h1234_5678);

    // Continuous contention without lock: p1 wins every 9th cycle
    rst = 1; idle_inputs(); step(o0, o1); rst = 0;
    p0_req = 1; p0_addr = AW'(1); p1_req = 1; p1_addr = AW'(2);
    for (int c = 1; c <= 20; c++) begin
      step(o0, o1);
      chk("starve_p1", 32'(o1), 32'((c % 9) == 0));
      chk("starve_p0", 32'(o0), 32'((c % 9) != 0));
    end

    // Locked burst with p0 always requesting: p1 owns cycles 9..24
    rst = 1; idle_inputs(); step(o0, o1); rst = 0;
    p0_req = 1; p0_addr = AW'(1); p1_req = 1; p1_addr = AW'(2); p1_lock = 1;
    for (int c = 1; c <= 30; c++) begin
      step(o0, o1);
      chk("burst_p1", 32'(o1), 32'(c >= 9 && c <= 24));
    end

    // Lock dropped on beat 4: beat 4 to p1, beat 5 to p0
    rst = 1; idle_inputs(); step(o0, o1); rst = 0;
    p1_req = 1; p1_addr = AW'(7); p1_lock = 1;
    step(o0, o1);
    chk("drop_b1", 32'(o1), 32'd1);
    p0_req = 1; p0_addr = AW'(8);
    step(o0, o1); chk("drop_b2", 32'(o1), 32'd1);
    step(o0, o1); chk("drop_b3", 32'(o1), 32'd1);
    p1_lock = 0;
    step(o0, o1); chk("drop_b4", 32'(o1), 32'd1);
    step(o0, o1); chk("drop_b5_p0", 32'(o0), 32'd1);

    // Reset in the middle of a burst
    rst = 1; idle_inputs(); step(o0, o1); rst = 0;
    p1_req = 1; p1_addr = AW'(9); p1_lock = 1;
    step(o0, o1);
    p0_req = 1; p0_addr = AW'(10);
    step(o0, o1);
    chk("mid_burst_p1", 32'(o1), 32'd1);
    rst = 1;
    step(o0, o1);
    chk("rst_gnt0", 32'(o0), 32'd0);
    chk("rst_gnt1", 32'(o1), 32'd0);
    chk("rst_rvalid1", 32'(p1_rvalid), 32'd0);
    rst = 0;
    step(o0, o1);
    chk("after_rst_p0", 32'(o0), 32'd1);

`ifdef RISCV_DMEM_ARB_STATS_EN
    rst = 1; idle_inputs(); step(o0, o1); rst = 0;
    p0_req = 1; p1_req = 1;
    for (int c = 0; c < 10; c++) step(o0, o1);
    chk("conflict_10", 32'(conflict_cnt), 32'd10);
    rst = 1; idle_inputs(); step(o0, o1);
    chk("conflict_rst", 32'(conflict_cnt), 32'd0);
`endif

    // Random traffic; each port holds its transaction until granted
    rst = 1; idle_inputs(); step(o0, o1);
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!pend0 && $urandom_range(0, 2) != 0) begin
        pend0 = 1;
        p0_we = 1'($urandom_range(0, 1));
        p0_addr = AW'($urandom_range(0, 15));
        p0_wdata = $urandom;
      end
      if (!pend1 && $urandom_range(0, 2) != 0) begin
        pend1 = 1;
        p1_we = 1'($urandom_range(0, 1));
        p1_addr = AW'($urandom_range(0, 15));
        p1_wdata = $urandom;
      end
      p0_req = pend0;
      p1_req = pend1;
      p1_lock = ($urandom_range(0, 3) != 0);
      step(o0, o1);
      if (o0) pend0 = 0;
      if (o1) pend1 = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
